// File: rtl/pkt_buffer_reader.sv
// Dequeue-side packet buffer read controller.
// Takes one SOP descriptor at a time, walks the linked buffer words with
// first-word / advance strobes, and replays the returned words as an
// AXI4-Stream through a 2-entry output FIFO with credit-based flow control.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. A valid source holds its payload stable until that edge, and
// valid never waits on ready. s_desc_* and m_axis_* both follow this rule.
module pkt_buffer_reader #(
   parameter int ADDR_WIDTH           = 12,
   parameter int C_M_AXIS_DATA_WIDTH  = 256,
   parameter int C_M_AXIS_TUSER_WIDTH = 128,
   parameter int C_M_AXIS_PIFO_WIDTH  = 32,
   parameter int MAX_PKT_WORDS        = 64
) (
   input  logic                                clk,
   input  logic                                rstn,
   input  logic                                s_desc_valid,
   output logic                                s_desc_ready,
   input  logic [ADDR_WIDTH-1:0]               s_desc_sop_addr,
   output logic                                m_buf_rd_first_word_en,
   output logic [ADDR_WIDTH-1:0]               m_buf_rd_pkt_sop_addr,
   output logic                                m_buf_rd_en,
   input  logic [C_M_AXIS_DATA_WIDTH-1:0]      s_buf_tdata,
   input  logic [C_M_AXIS_DATA_WIDTH/8-1:0]    s_buf_tkeep,
   input  logic                                s_buf_tlast,
   input  logic [C_M_AXIS_TUSER_WIDTH-1:0]     s_buf_tuser,
   input  logic [C_M_AXIS_PIFO_WIDTH-1:0]      s_buf_tpifo,
   output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
   output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
   output logic                                m_axis_tlast,
   output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
   output logic [C_M_AXIS_PIFO_WIDTH-1:0]      m_axis_tpifo,
   output logic                                m_axis_tvalid,
   input  logic                                m_axis_tready,
   output logic                                busy,
   output logic [31:0]                         pkt_count,
   output logic                                err_overlength,
   output logic [1:0]                          state_dbg
);

   localparam int KEEP_W = C_M_AXIS_DATA_WIDTH / 8;
   localparam int WC_W   = $clog2(MAX_PKT_WORDS + 1);
   localparam logic [WC_W-1:0] WC_MAX = WC_W'(MAX_PKT_WORDS);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FIRST  = 2'd1,
      STREAM = 2'd2
   } state_t;

   state_t                  state;
   logic                    alive;      // low until the first edge after reset
   logic [ADDR_WIDTH-1:0]   sop_q;
   logic [WC_W-1:0]         wc;         // words requested for this packet
   logic                    inflight;   // a strobe was issued last cycle

   logic [C_M_AXIS_DATA_WIDTH-1:0]  data_mem [2];
   logic [KEEP_W-1:0]               keep_mem [2];
   logic                            last_mem [2];
   logic [C_M_AXIS_TUSER_WIDTH-1:0] user_mem [2];
   logic [C_M_AXIS_PIFO_WIDTH-1:0]  pifo_mem [2];
   logic                            wr_ptr;
   logic                            rd_ptr;
   logic [1:0]                      occ;

   logic       pop;
   logic       push;
   logic       push_last;
   logic       at_max;
   logic [2:0] credit_sum;
   logic       credit;
   logic       first_en;
   logic       adv_en;

   // Flow control and strobe decisions; advance is combinational on returned tlast
   always_comb begin
      pop        = (occ != 2'd0) && m_axis_tready;
      push       = inflight;
      at_max     = (wc == WC_MAX);
      push_last  = s_buf_tlast || at_max;
      credit_sum = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
      credit     = (credit_sum <= 3'd1);
      first_en   = (state == FIRST) && credit;
      adv_en     = 1'b0;
      if (state == STREAM && credit) begin
         adv_en = inflight ? (!s_buf_tlast && !at_max) : 1'b1;
      end
   end

   assign s_desc_ready           = alive && (state == IDLE);
   assign m_buf_rd_first_word_en = first_en;
   assign m_buf_rd_pkt_sop_addr  = first_en ? sop_q : '0;
   assign m_buf_rd_en            = adv_en;
   assign m_axis_tvalid          = (occ != 2'd0);
   assign m_axis_tdata           = data_mem[rd_ptr];
   assign m_axis_tkeep           = keep_mem[rd_ptr];
   assign m_axis_tlast           = last_mem[rd_ptr];
   assign m_axis_tuser           = user_mem[rd_ptr];
   assign m_axis_tpifo           = pifo_mem[rd_ptr];
   assign busy                   = (state != IDLE) || (occ != 2'd0);
   assign state_dbg              = state;

   // Read FSM: descriptor capture, word counting, overlength truncation
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state          <= IDLE;
         alive          <= 1'b0;
         sop_q          <= '0;
         wc             <= '0;
         inflight       <= 1'b0;
         err_overlength <= 1'b0;
      end else begin
         alive    <= 1'b1;
         inflight <= first_en || adv_en;
         case (state)
            IDLE: begin
               if (s_desc_valid && s_desc_ready) begin
                  sop_q <= s_desc_sop_addr;
                  wc    <= '0;
                  state <= FIRST;
               end
            end
            FIRST: begin
               if (first_en) begin
                  wc    <= WC_W'(1);
                  state <= STREAM;
               end
            end
            STREAM: begin
               if (inflight && push_last) begin
                  state <= IDLE;
                  if (!s_buf_tlast) err_overlength <= 1'b1;
               end else if (adv_en) begin
                  wc <= wc + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Two-entry output FIFO; returned words land here in their return cycle
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         occ    <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            data_mem[i] <= '0;
            keep_mem[i] <= '0;
            last_mem[i] <= 1'b0;
            user_mem[i] <= '0;
            pifo_mem[i] <= '0;
         end
      end else begin
         if (push) begin
            data_mem[wr_ptr] <= s_buf_tdata;
            keep_mem[wr_ptr] <= s_buf_tkeep;
            last_mem[wr_ptr] <= push_last;
            user_mem[wr_ptr] <= s_buf_tuser;
            pifo_mem[wr_ptr] <= s_buf_tpifo;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         occ <= occ + {1'b0, push} - {1'b0, pop};
      end
   end

   // Completed-packet counter, counts forced tlast as well
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pkt_count <= '0;
      end else if (pop && last_mem[rd_ptr]) begin
         pkt_count <= pkt_count + 32'd1;
      end
   end

endmodule
